// File: rtl/uart_job_master.sv
// uart_job_master: host-side UART job protocol initiator; builds CRC-protected packets, parses miner replies.
module uart_job_master #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000,
  parameter int MAX_RETRY = 2
) (
  input  logic         comm_clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_type,
  input  logic [415:0] job,
  output logic         transmit,
  output logic [7:0]   tx_byte,
  input  logic         is_transmitting,
  input  logic         received,
  input  logic [7:0]   rx_byte,
  output logic         done,
  output logic [2:0]   status,
  output logic [31:0]  info_word,
  output logic [31:0]  info_nonce,
  output logic         nonce_valid,
  output logic [31:0]  nonce_out
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  typedef enum logic {P_LEN, P_BODY} pstate_t;
  state_t state, state_n;
  pstate_t ps;
  logic [1:0] cmd_q;
  logic [415:0] job_q;
  logic [7:0] retry, ptype;
  logic [5:0] idx, off, plen, pcnt, n;
  logic [6:0] len;
  logic [31:0] crc, w0, w1;
  logic [23:0] cnt, gap;
  logic tx1, tx2, accept, ill, in_wait, in_crc, last_tx;
  logic rx_first, good_first, short_r, bad_first, rx_last;
  logic info, inval, resend, nonce, other, ok, bad, inv, rs, tmo, retry_go, fin;
  logic [2:0] st;
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {d, 24'h0};
    for (int i = 0; i < 8; i++) r = r[31] ? {r[30:0], 1'b0} ^ 32'h04C11DB7 : {r[30:0], 1'b0};
    return r;
  endfunction
  assign cmd_ready = state == IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign ill = accept && cmd_type == 2'd3;
  assign in_wait = state == WAIT;
  assign len = cmd_q == 2'd2 ? 7'd60 : cmd_q == 2'd1 ? 7'd8 : 7'd1;
  assign in_crc = {1'b0, idx} + 7'd4 >= len;
  assign off = idx - 6'd4;
  // Pacing: at most one byte every three cycles, and never while the uart is busy.
  assign transmit = !reset && state == SEND && !is_transmitting && !tx1 && !tx2;
  assign tx_byte = (state != SEND || cmd_q == 2'd0 || idx == 6'd1 || idx == 6'd2) ? 8'h00 :
                   idx == 6'd0 ? {1'b0, len} :
                   idx == 6'd3 ? {6'b0, cmd_q[1], 1'b0} :
                   in_crc ? crc[31:24] : job_q[{off, 3'b000} +: 8];
  assign last_tx = transmit && {1'b0, idx} == len - 7'd1;
  assign n = pcnt + 6'd1;
  assign rx_first = received && ps == P_LEN;
  assign good_first = rx_first && rx_byte >= 8'd8 && rx_byte <= 8'd60;
  assign short_r = rx_first && rx_byte == 8'd1;
  assign bad_first = rx_first && !good_first && !short_r;
  assign rx_last = received && ps == P_BODY && n == plen;
  assign info = rx_last && ptype == 8'd0 && plen == 6'd16;
  assign inval = rx_last && ptype == 8'd1;
  assign resend = rx_last && ptype == 8'd5;
  assign nonce = rx_last && ptype == 8'd3 && plen == 6'd8;
  assign other = rx_last && !(info || inval || resend || nonce);
  assign ok = in_wait && (short_r || (info && cmd_q == 2'd1));
  assign bad = in_wait && (bad_first || other || (info && cmd_q != 2'd1));
  assign inv = in_wait && inval;
  assign rs = in_wait && resend;
  // Any received byte clears the silence counter, so a reply always beats a coincident expiry.
  assign tmo = in_wait && !received && cnt == TIMEOUT_CYCLES - 24'd1;
  assign retry_go = rs && 32'(retry) < MAX_RETRY;
  assign fin = ok || bad || inv || (rs && !retry_go) || tmo;
  assign st = ok ? 3'd0 : inv ? 3'd1 : rs ? 3'd2 : tmo ? 3'd3 : 3'd4;
  always_comb begin
    state_n = state;
    if (state == IDLE && accept && !ill) state_n = SEND;
    if (state == SEND && last_tx) state_n = WAIT;
    if (in_wait) state_n = retry_go ? SEND : fin ? IDLE : WAIT;
  end
  always_ff @(posedge comm_clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge comm_clk) begin
    if (reset) begin
      ps <= P_LEN;
      cmd_q <= 2'd0;
      retry <= 8'd0;
      idx <= 6'd0;
      crc <= 32'h0;
      cnt <= 24'd0;
      gap <= 24'd0;
      tx1 <= 1'b0;
      tx2 <= 1'b0;
      plen <= 6'd0;
      pcnt <= 6'd0;
      ptype <= 8'd0;
      w0 <= 32'h0;
      w1 <= 32'h0;
      done <= 1'b0;
      status <= 3'd0;
      info_word <= 32'h0;
      info_nonce <= 32'h0;
      nonce_valid <= 1'b0;
      nonce_out <= 32'h0;
    end else begin
      tx1 <= transmit;
      tx2 <= tx1;
      done <= fin || ill;
      if (fin || ill) status <= ill ? 3'd4 : st;
      nonce_valid <= nonce;
      if (nonce) nonce_out <= {w0[23:0], rx_byte};
      if (ok && info) begin
        info_word <= w0;
        info_nonce <= w1;
      end
      if (accept) begin
        cmd_q <= cmd_type;
        job_q <= job;
        retry <= 8'd0;
      end
      if (accept || retry_go) begin
        idx <= 6'd0;
        crc <= 32'hFFFFFFFF;
      end
      if (retry_go) retry <= retry + 8'd1;
      if (transmit) begin
        idx <= idx + 6'd1;
        crc <= in_crc ? {crc[23:0], 8'h00} : crc_step(crc, tx_byte);
      end
      cnt <= (last_tx || received) ? 24'd0 : cnt == TIMEOUT_CYCLES ? cnt : cnt + 24'd1;
      if (good_first) begin
        ps <= P_BODY;
        plen <= rx_byte[5:0];
        pcnt <= 6'd1;
        gap <= 24'd0;
      end else if (ps == P_BODY) begin
        if (received) begin
          pcnt <= n;
          gap <= 24'd0;
          if (n == 6'd4) ptype <= rx_byte;
          if (n >= 6'd5 && n <= 6'd8) w0 <= {w0[23:0], rx_byte};
          if (n >= 6'd9 && n <= 6'd12) w1 <= {w1[23:0], rx_byte};
          if (rx_last) ps <= P_LEN;
        end else if (gap == TIMEOUT_CYCLES - 24'd1) ps <= P_LEN;
        else gap <= gap + 24'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_job_master.sv
// tb_uart_job_master: directed self-checking bench acting as the miner side of the link.
module tb_uart_job_master;
  localparam logic [23:0] TMO = 24'd40;
  logic comm_clk = 0, reset = 1, cmd_valid = 0, is_transmitting = 0, received = 0;
  logic [1:0] cmd_type = 0;
  logic [415:0] job = 0;
  logic [7:0] rx_byte = 0;
  logic cmd_ready, transmit, done, nonce_valid;
  logic [7:0] tx_byte;
  logic [2:0] status;
  logic [31:0] info_word, info_nonce, nonce_out;
  uart_job_master #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(2)) dut (
    .comm_clk(comm_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .job(job), .transmit(transmit), .tx_byte(tx_byte),
    .is_transmitting(is_transmitting), .received(received), .rx_byte(rx_byte),
    .done(done), .status(status), .info_word(info_word), .info_nonce(info_nonce),
    .nonce_valid(nonce_valid), .nonce_out(nonce_out));
  always #5 comm_clk = ~comm_clk;
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, nv_cnt = 0, viol = 0;
  int acc_cyc = 0, done_cyc = 0, rx_cyc = 0, nv_cyc = 0, last_tx_cyc = -10;
  logic [2:0] last_status = 0;
  logic rdy_at_done = 0;
  logic [7:0] q[$];
  int tq[$];
  always @(posedge comm_clk) begin
    cyc++;
    if (transmit) begin
      if (cyc - last_tx_cyc < 3) viol++;
      last_tx_cyc = cyc;
      q.push_back(tx_byte);
      tq.push_back(cyc);
    end
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (received) rx_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      last_status = status;
      rdy_at_done = cmd_ready;
    end
    if (nonce_valid) begin
      nv_cnt++;
      nv_cyc = cyc;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge comm_clk);
  endtask
  task automatic issue(input logic [1:0] t, input logic [415:0] j);
    @(negedge comm_clk);
    cmd_valid = 1;
    cmd_type = t;
    job = j;
    @(negedge comm_clk);
    cmd_valid = 0;
  endtask
  task automatic wait_tx(input int k);
    int c = 0;
    while (q.size() < k && c < 2000) begin
      @(negedge comm_clk);
      c++;
    end
    chk("wait_tx", 64'(q.size() >= k), 64'd1);
  endtask
  task automatic wait_done(input int prev, input int lim);
    int c = 0;
    while (done_cnt == prev && c < lim) begin
      @(negedge comm_clk);
      c++;
    end
    chk("wait_done", 64'(done_cnt), 64'(prev + 1));
  endtask
  task automatic rx_pkt(input logic [127:0] d, input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge comm_clk);
      received = 1;
      rx_byte = d[8*(k-1-i) +: 8];
      @(negedge comm_clk);
      received = 0;
    end
  endtask
  function automatic logic [31:0] crc_res(input int s, input int k);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < k; i++) begin
      c = c ^ {q[s+i], 24'h0};
      for (int b = 0; b < 8; b++) c = c[31] ? {c[30:0], 1'b0} ^ 32'h04C11DB7 : {c[30:0], 1'b0};
    end
    return c;
  endfunction
  initial begin
    logic [415:0] jv;
    int base, nd, e;
    for (int i = 0; i < 52; i++) jv[i*8 +: 8] = 8'(i * 3 + 1);
    tick(3);
    reset = 0;
    tick(1);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_transmit", 64'(transmit), 64'd0);
    chk("rst_tx_byte", 64'(tx_byte), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_info", {info_word, info_nonce}, 64'd0);
    chk("rst_nonce", {31'd0, nonce_valid, nonce_out}, 64'd0);
    issue(2'd1, '0);
    chk("cmd_ready_drop", 64'(cmd_ready), 64'd0);
    wait_tx(8);
    chk("gi_first_tx_latency", 64'(tq[0] - acc_cyc), 64'd1);
    chk("gi_len", 64'(q[0]), 64'h08);
    chk("gi_hdr", {40'd0, q[1], q[2], q[3]}, 64'd0);
    chk("gi_crc_residue", 64'(crc_res(0, 8)), 64'd0);
    rx_pkt(128'h10000000_DEADBEEF_00001234_00000000, 16);
    tick(2);
    chk("gi_done_cnt", 64'(done_cnt), 64'd1);
    chk("gi_status", 64'(last_status), 64'd0);
    chk("gi_info_word", 64'(info_word), 64'hDEADBEEF);
    chk("gi_info_nonce", 64'(info_nonce), 64'h00001234);
    chk("gi_done_latency", 64'(done_cyc - rx_cyc), 64'd1);
    chk("gi_ready_at_done", 64'(rdy_at_done), 64'd1);
    base = q.size();
    issue(2'd2, jv);
    wait_tx(base + 60);
    chk("pj_len", 64'(q[base]), 64'h3C);
    chk("pj_type", 64'(q[base+3]), 64'h02);
    chk("pj_byte5", 64'(q[base+4]), 64'h01);
    e = 0;
    for (int i = 4; i < 56; i++) if (q[base+i] !== jv[(i-4)*8 +: 8]) e++;
    chk("pj_payload_errs", 64'(e), 64'd0);
    chk("pj_crc_residue", 64'(crc_res(base, 60)), 64'd0);
    rx_pkt(128'h01, 1);
    tick(2);
    chk("pj_done_cnt", 64'(done_cnt), 64'd2);
    chk("pj_status", 64'(last_status), 64'd0);
    base = q.size();
    issue(2'd2, jv);
    wait_tx(base + 60);
    rx_pkt(128'h08000005_00000000, 8);
    wait_tx(base + 120);
    rx_pkt(128'h08000005_00000000, 8);
    wait_tx(base + 180);
    chk("rs_no_early_done", 64'(done_cnt), 64'd2);
    rx_pkt(128'h08000005_00000000, 8);
    tick(10);
    chk("rs_done_cnt", 64'(done_cnt), 64'd3);
    chk("rs_status", 64'(last_status), 64'd2);
    chk("rs_tx_total", 64'(q.size() - base), 64'd180);
    e = 0;
    for (int i = 0; i < 60; i++) if (q[base+i] !== q[base+60+i] || q[base+i] !== q[base+120+i]) e++;
    chk("rs_identical", 64'(e), 64'd0);
    base = q.size();
    nd = done_cnt;
    issue(2'd0, '0);
    wait_tx(base + 1);
    chk("ping_byte", 64'(q[base]), 64'h00);
    wait_done(nd, 200);
    chk("ping_status", 64'(last_status), 64'd3);
    chk("ping_timeout_cycles", 64'(done_cyc - tq[base]), 64'(TMO + 1));
    tick(3);
    chk("ping_single_byte", 64'(q.size() - base), 64'd1);
    base = q.size();
    issue(2'd2, jv);
    wait_tx(base + 60);
    nd = done_cnt;
    rx_pkt(128'h08000003_CAFEBABE, 8);
    tick(2);
    chk("nc_valid_cnt", 64'(nv_cnt), 64'd1);
    chk("nc_value", 64'(nonce_out), 64'hCAFEBABE);
    chk("nc_latency", 64'(nv_cyc - rx_cyc), 64'd1);
    chk("nc_no_done", 64'(done_cnt), 64'(nd));
    rx_pkt(128'h01, 1);
    tick(2);
    chk("nc_done_cnt", 64'(done_cnt), 64'(nd + 1));
    chk("nc_status", 64'(last_status), 64'd0);
    base = q.size();
    issue(2'd1, '0);
    wait_tx(base + 8);
    rx_pkt(128'h08000001_00000000, 8);
    tick(2);
    chk("inv_status", 64'(last_status), 64'd1);
    base = q.size();
    nd = done_cnt;
    issue(2'd1, '0);
    wait_tx(base + 8);
    rx_pkt(128'h05, 1);
    tick(2);
    chk("bad_first_done", 64'(done_cnt), 64'(nd + 1));
    chk("bad_first_status", 64'(last_status), 64'd4);
    chk("bad_info_kept", 64'(info_word), 64'hDEADBEEF);
    base = q.size();
    nd = done_cnt;
    issue(2'd3, '0);
    tick(4);
    chk("ill_done", 64'(done_cnt), 64'(nd + 1));
    chk("ill_latency", 64'(done_cyc - acc_cyc), 64'd1);
    chk("ill_status", 64'(last_status), 64'd4);
    chk("ill_no_tx", 64'(q.size()), 64'(base));
    base = q.size();
    issue(2'd2, jv);
    wait_tx(base + 30);
    nd = done_cnt;
    reset = 1;
    @(negedge comm_clk);
    reset = 0;
    chk("mr_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mr_transmit", 64'(transmit), 64'd0);
    chk("mr_tx_byte", 64'(tx_byte), 64'd0);
    chk("mr_status", 64'(status), 64'd0);
    chk("mr_info", {info_word, info_nonce}, 64'd0);
    chk("mr_nonce_out", 64'(nonce_out), 64'd0);
    tick(50);
    chk("mr_no_more_tx", 64'(q.size()), 64'(base + 30));
    chk("mr_no_done", 64'(done_cnt), 64'(nd));
    chk("tx_spacing_violations", 64'(viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
